// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: groups the fetch/execute handshake and the PC datapath
// signals of the PC sequencer.
//   master : the surrounding CPU side (drives start, pc_cur, imem_ack,
//            exec_done, branch/jump requests, halt_instr)
//   slave  : the sequencer (drives pc_next, pc_hold, imem_req, ir_we,
//            state, busy, trap)
interface pc_sequencer_if;
  logic        start;
  logic [31:0] pc_cur;
  logic        imem_ack;
  logic        exec_done;
  logic        br_taken;
  logic [31:0] br_offset;
  logic        jmp;
  logic [25:0] jmp_target;
  logic        jr;
  logic [31:0] jr_addr;
  logic        halt_instr;
  logic [31:0] pc_next;
  logic        pc_hold;
  logic        imem_req;
  logic        ir_we;
  logic [2:0]  state;
  logic        busy;
  logic        trap;

  modport master (
    output start, pc_cur, imem_ack, exec_done, br_taken, br_offset,
           jmp, jmp_target, jr, jr_addr, halt_instr,
    input  pc_next, pc_hold, imem_req, ir_we, state, busy, trap
  );

  modport slave (
    input  start, pc_cur, imem_ack, exec_done, br_taken, br_offset,
           jmp, jmp_target, jr, jr_addr, halt_instr,
    output pc_next, pc_hold, imem_req, ir_we, state, busy, trap
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction sequencing FSM (IDLE/FETCH/EXEC/UPDATE/HALTED)
// that computes the next PC and controls the PC register load.
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : pc_sequencer_if.slave
//          in : start, pc_cur, imem_ack, exec_done, br_taken/br_offset,
//               jmp/jmp_target, jr/jr_addr, halt_instr
//          out: pc_next (registered), pc_hold, imem_req, ir_we, state,
//               busy, trap
// Optional feature: define PC_ALIGN_TRAP_EN to redirect a misaligned
// target to TRAP_VEC and pulse trap during UPDATE. Without it the low two
// target bits are cleared and trap is tied low.
module pc_sequencer #(
  parameter logic [31:0] TRAP_VEC = 32'h0000_0080
) (
  input logic         clk,
  input logic         rst,
  pc_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    UPDATE = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic        [31:0] pc_next_p0;
  logic        [31:0] pc_plus4;
  logic signed [31:0] br_off_s;
  logic signed [31:0] br_sum;
  logic        [31:0] target;
  logic               load_pc;

  // Target after alignment handling: trap vector or low bits cleared.
  function automatic logic [31:0] align_target(input logic [31:0] t);
`ifdef PC_ALIGN_TRAP_EN
    return (t[1:0] != 2'b00) ? TRAP_VEC : t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  assign pc_plus4 = bus.pc_cur + 32'd4;
  assign br_off_s = signed'(bus.br_offset);
  assign br_sum   = signed'(pc_plus4) + (br_off_s <<< 2);

  // Highest priority request wins: jr, then jmp, then branch.
  always_comb begin
    target = pc_plus4;
    if (bus.jr)
      target = bus.jr_addr;
    else if (bus.jmp)
      target = {pc_plus4[31:28], bus.jmp_target, 2'b00};
    else if (bus.br_taken)
      target = br_sum;
  end

  assign load_pc = (state_q == EXEC) && bus.exec_done;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = FETCH;
      FETCH:   if (bus.imem_ack) state_d = EXEC;
      EXEC:    if (bus.exec_done) state_d = bus.halt_instr ? HALTED : UPDATE;
      UPDATE:  state_d = FETCH;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Stage p0: next PC captured on the completing EXEC edge, held afterwards.
  always_ff @(posedge clk) begin
    if (rst)          pc_next_p0 <= 32'd0;
    else if (load_pc) pc_next_p0 <= align_target(target);
  end

`ifdef PC_ALIGN_TRAP_EN
  logic trap_p0;

  always_ff @(posedge clk) begin
    if (rst)          trap_p0 <= 1'b0;
    else if (load_pc) trap_p0 <= (target[1:0] != 2'b00);
  end

  assign bus.trap = !rst && (state_q == UPDATE) && trap_p0;
`else
  assign bus.trap = 1'b0;
`endif

  // Reset is also applied to the outputs directly so that the reset view
  // is presented for the whole time rst is high, even mid-fetch.
  always_comb begin
    bus.pc_hold  = 1'b1;
    bus.imem_req = 1'b0;
    bus.busy     = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH:   begin bus.imem_req = 1'b1; bus.busy = 1'b1; end
        EXEC:    bus.busy = 1'b1;
        UPDATE:  begin bus.pc_hold = 1'b0; bus.busy = 1'b1; end
        default: ;
      endcase
    end
  end

  assign bus.ir_we   = bus.imem_req & bus.imem_ack;
  assign bus.state   = rst ? 3'd0 : 3'(state_q);
  assign bus.pc_next = rst ? 32'd0 : pc_next_p0;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench for pc_sequencer with a reference model
// compared on every negative clock edge plus literal expectations.
module tb_pc_sequencer;

  logic clk = 1'b0;
  logic rst;
  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int fail_prints = 0;
  bit done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (fail_prints < 40) begin
        fail_prints++;
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
    end
  endtask

  // Reference model: PC target from the architectural rules.
  function automatic logic [31:0] model_target(
    input logic [31:0] pc, input logic br, input logic [31:0] off,
    input logic j, input logic [25:0] jt, input logic r, input logic [31:0] ra);
    logic [31:0] seq;
    seq = pc + 32'd4;
    if (r)  return ra;
    if (j)  return (seq & 32'hF000_0000) + ({6'b0, jt} * 32'd4);
    if (br) return seq + off * 32'd4;
    return seq;
  endfunction

  localparam int S_IDLE = 0, S_FETCH = 1, S_EXEC = 2, S_UPDATE = 3, S_HALTED = 4;

  int          m_st = S_IDLE;
  logic [31:0] m_pc = 32'd0;
  logic        m_trap = 1'b0;
  int          hold_low_cnt = 0;
  int          we_cnt = 0;

  always @(posedge clk) begin
    logic [31:0] t;
    if (rst) begin
      m_st = S_IDLE; m_pc = 32'd0; m_trap = 1'b0;
    end else begin
      case (m_st)
        S_IDLE:   if (bus.start) m_st = S_FETCH;
        S_FETCH:  if (bus.imem_ack) m_st = S_EXEC;
        S_EXEC:   if (bus.exec_done) begin
          t = model_target(bus.pc_cur, bus.br_taken, bus.br_offset, bus.jmp,
                           bus.jmp_target, bus.jr, bus.jr_addr);
`ifdef PC_ALIGN_TRAP_EN
          m_trap = (t % 4) != 0;
          m_pc   = m_trap ? 32'h80 : t;
`else
          m_trap = 1'b0;
          m_pc   = t - (t % 4);
`endif
          m_st = bus.halt_instr ? S_HALTED : S_UPDATE;
        end
        S_UPDATE: m_st = S_FETCH;
        default:  ;
      endcase
    end
    @(negedge clk);
    if (!done) begin
      check("model_state", {29'd0, bus.state}, rst ? 32'd0 : 32'(m_st));
      check("model_pc_next", bus.pc_next, rst ? 32'd0 : m_pc);
      check("model_pc_hold", {31'd0, bus.pc_hold}, {31'd0, rst || m_st != S_UPDATE});
      check("model_imem_req", {31'd0, bus.imem_req}, {31'd0, !rst && m_st == S_FETCH});
      check("model_ir_we", {31'd0, bus.ir_we}, {31'd0, !rst && m_st == S_FETCH && bus.imem_ack});
      check("model_busy", {31'd0, bus.busy},
            {31'd0, !rst && m_st >= S_FETCH && m_st <= S_UPDATE});
      check("model_trap", {31'd0, bus.trap}, {31'd0, !rst && m_st == S_UPDATE && m_trap});
      if (!bus.pc_hold) hold_low_cnt++;
      if (bus.ir_we)    we_cnt++;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One instruction from FETCH through the completing EXEC edge; ends at the
  // negedge after that edge and checks the literal expectations there.
  task automatic instr(
    input logic [31:0] pc, input logic br, input logic [31:0] off,
    input logic j, input logic [25:0] jt, input logic r, input logic [31:0] ra,
    input logic h, input int ack_dly,
    input logic [31:0] exp_pc, input logic exp_trap, input logic [2:0] exp_state);
    step;
    bus.start = 1'b0;
    bus.pc_cur = pc; bus.br_taken = br; bus.br_offset = off;
    bus.jmp = j; bus.jmp_target = jt; bus.jr = r; bus.jr_addr = ra;
    bus.imem_ack = 1'b0; bus.exec_done = 1'b0; bus.halt_instr = 1'b0;
    repeat (ack_dly) step;
    bus.imem_ack = 1'b1;
    step;
    bus.imem_ack = 1'b0;
    step;
    bus.exec_done = 1'b1; bus.halt_instr = h;
    step;
    bus.exec_done = 1'b0; bus.halt_instr = 1'b0;
    bus.br_taken = 1'b0; bus.jmp = 1'b0; bus.jr = 1'b0;
    @(negedge clk);
    check("lit_pc_next", bus.pc_next, exp_pc);
    check("lit_trap", {31'd0, bus.trap}, {31'd0, exp_trap});
    check("lit_state", {29'd0, bus.state}, {29'd0, exp_state});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int hl0, we0;
    logic [31:0] held_pc;
    rst = 1'b1;
    bus.start = 1'b0; bus.pc_cur = 32'd0; bus.imem_ack = 1'b0; bus.exec_done = 1'b0;
    bus.br_taken = 1'b0; bus.br_offset = 32'd0; bus.jmp = 1'b0; bus.jmp_target = 26'd0;
    bus.jr = 1'b0; bus.jr_addr = 32'd0; bus.halt_instr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", {29'd0, bus.state}, 32'd0);
    check("rst_pc_next", bus.pc_next, 32'd0);
    check("rst_pc_hold", {31'd0, bus.pc_hold}, 32'd1);
    check("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_trap", {31'd0, bus.trap}, 32'd0);

    step;
    rst = 1'b0; bus.start = 1'b1;
    hl0 = hold_low_cnt; we0 = we_cnt;
    instr(32'h0, 0, 32'd0, 0, 26'd0, 0, 32'd0, 0, 2, 32'h4, 1'b0, 3'd3);
    step;
    check("hold_low_once", 32'(hold_low_cnt - hl0), 32'd1);
    check("ir_we_once", 32'(we_cnt - we0), 32'd1);

    instr(32'h100, 1, 32'hFFFF_FFFE, 0, 26'd0, 0, 32'd0, 0, 1, 32'hFC, 1'b0, 3'd3);
    instr(32'h100, 1, 32'd5, 1, 26'h3FF, 1, 32'h400, 0, 0, 32'h400, 1'b0, 3'd3);
    instr(32'hFFFF_FFFC, 0, 32'd0, 0, 26'd0, 0, 32'd0, 0, 0, 32'h0, 1'b0, 3'd3);
`ifdef PC_ALIGN_TRAP_EN
    instr(32'h10, 0, 32'd0, 0, 26'd0, 1, 32'h202, 0, 1, 32'h80, 1'b1, 3'd3);
`else
    instr(32'h10, 0, 32'd0, 0, 26'd0, 1, 32'h202, 0, 1, 32'h200, 1'b0, 3'd3);
`endif
    instr(32'h1000_0000, 1, 32'd7, 1, 26'h123, 0, 32'd0, 0, 0, 32'h1000_048C, 1'b0, 3'd3);
    instr(32'h20, 1, 32'd3, 0, 26'd0, 0, 32'd0, 0, 1, 32'h30, 1'b0, 3'd3);
    instr(32'h40, 0, 32'd0, 0, 26'd0, 0, 32'd0, 1, 0, 32'h44, 1'b0, 3'd4);

    held_pc = 32'h44;
    for (int i = 0; i < 10; i++) begin
      step;
      bus.start = 1'b1;
      @(negedge clk);
      check("halt_pc_hold", {31'd0, bus.pc_hold}, 32'd1);
      check("halt_state", {29'd0, bus.state}, 32'd4);
      check("halt_pc_next", bus.pc_next, held_pc);
    end

    step;
    bus.start = 1'b0; rst = 1'b1;
    step;
    rst = 1'b0; bus.start = 1'b1;
    step;
    bus.start = 1'b0;
    @(negedge clk);
    check("fetch_imem_req", {31'd0, bus.imem_req}, 32'd1);
    check("fetch_state", {29'd0, bus.state}, 32'd1);
    step;
    rst = 1'b1;
    step;
    @(negedge clk);
    check("rst_fetch_imem_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_fetch_state", {29'd0, bus.state}, 32'd0);
    check("rst_fetch_pc_next", bus.pc_next, 32'd0);
    step;
    rst = 1'b0;
    repeat (2) step;
    done = 1'b1;
    step;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
